msx_cart_bus_if: RTL and testbench
==================================

Name: msx_cart_bus_if

Overview:
Parametrised MSX cartridge slot bus front end for the tang20cart_msx family.
- Samples the asynchronous slot strobes (n_ce, n_wr, n_rd), address and data.
- Converts each slot access into one valid/ready request on the internal bus.
- Drives read data back onto the slot with the output enable used for tdir.
- Stretches the slot cycle through twait until the internal target responds.
- Generalises the fixed 2-bit-address, no-wait interface to any address width, with wait-state insertion and configurable synchroniser depth.

Parameters:
ADDR_W, 2, width of slot address ta and bus_address
SYNC_STAGES, 2, flip-flop depth of strobe synchronisers (legal range 2..4)
TIMEOUT_CYCLES, 255, clk cycles before a stalled request is abandoned (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
n_ce  in  1  slot chip enable, active low, asynchronous to clk
n_wr  in  1  slot write strobe, active low
n_rd  in  1  slot read strobe, active low
ta  in  ADDR_W  slot address
td_in  in  8  slot data bus input
td_out  out  8  slot read data
td_oe  out  1  slot data output enable (1 = block drives td; top level derives tdir from it)
twait  out  1  slot wait request, active high (inverted at the pad)
bus_valid  out  1  internal request valid
bus_ready  in  1  internal request accepted
bus_write  out  1  1 = write request, 0 = read request
bus_address  out  ADDR_W  latched request address
bus_wdata  out  8  latched write data
bus_rdata  in  8  read data from target
bus_rdata_en  in  1  one-cycle pulse qualifying bus_rdata

Behaviour:
- Reset values: td_out=8'h00, td_oe=0, twait=0, bus_valid=0, bus_write=0, bus_address=0, bus_wdata=8'h00. All synchroniser flops reset to 1. FSM resets to IDLE.
- Reset is asynchronous. Asserting it mid-access forces every output to its reset value immediately; any pending request is dropped without a handshake.
- Synchronisation: n_ce, n_wr and n_rd each pass through SYNC_STAGES flops; s_ce, s_wr, s_rd denote the active-high synchronised strobes. ta and td_in are not synchronised; they are captured only when the START condition fires, while the slot holds them stable.
- START condition (evaluated in IDLE only): s_ce=1 and exactly one of s_wr, s_rd =1.
  - Both strobes asserted together: illegal; stay in IDLE with no request.
  - s_ce without a strobe: ignored.
- FSM states:
  - IDLE:
    - On START: latch bus_address<=ta, bus_write<=s_wr, bus_wdata<=td_in (write only); set bus_valid=1 and twait=1; go to REQ.
    - Latency from the strobe edge to bus_valid: SYNC_STAGES+1 clk cycles.
  - REQ:
    - Hold bus_valid and all bus_* outputs stable until bus_ready=1. bus_valid drops in the cycle after the handshake.
    - On handshake, write: twait<=0, go to RELEASE.
    - On handshake, read: go to RD_WAIT.
    - If bus_rdata_en=1 in the same cycle as bus_ready: take the RD_WAIT exit immediately and go to DRIVE.
  - RD_WAIT (twait=1):
    - On bus_rdata_en: td_out<=bus_rdata, td_oe<=1, twait<=0, go to DRIVE.
  - DRIVE:
    - Hold td_out and td_oe until s_rd=0 or s_ce=0, then td_oe<=0 and go to RELEASE.
  - RELEASE:
    - Wait until s_ce=0 and s_wr=0 and s_rd=0, then go to IDLE.
    - This guarantees one request per slot cycle.
- Early strobe release: if the slot releases its strobes while in REQ or RD_WAIT, the handshake still completes.
  - A read in that case never asserts td_oe; the FSM goes directly to RELEASE.
  - twait still falls when the request completes.
- twait is a registered output; it is never high in IDLE or RELEASE.
- Back-to-back slot cycles: a new START is accepted only after passing through IDLE. The minimum gap is therefore 1 cycle in IDLE after RELEASE.

Optional Feature:
MSX_CART_BUS_TIMEOUT_EN
- Defined:
  - An 8..16-bit counter runs in REQ and RD_WAIT and clears on every state change.
  - When it reaches TIMEOUT_CYCLES: bus_valid<=0, twait<=0.
    - Read: td_out<=8'hFF, td_oe<=1, go to DRIVE.
    - Write: go to RELEASE.
  - A late bus_ready or bus_rdata_en arriving after a timeout is ignored.
- Undefined: no counter exists; the block waits indefinitely and twait may stay high forever.

Test Plan:
- Write, ADDR_W=2, bus_ready tied 1: n_ce=0, n_wr=0, ta=2'b10, td=8'hA5 -> exactly one bus_valid cycle with bus_write=1, bus_address=2, bus_wdata=8'hA5; twait high for 1 cycle; no second request while the strobes stay low.
- Read with delayed data: n_rd=0, ta=2'b01; bus_ready after 3 cycles, bus_rdata_en with 8'h3C 5 cycles later -> twait high from the REQ entry through RD_WAIT; td_out=8'h3C with td_oe=1 until n_rd rises, then td_oe=0 within SYNC_STAGES+1 cycles.
- Illegal or idle strobes: n_wr and n_rd low together, then n_ce low alone -> bus_valid never asserted, twait stays 0.
- Async reset mid-read in RD_WAIT: reset_n pulsed low -> td_oe, twait, bus_valid at 0 immediately; after release, a fresh write ta=0, td=8'h5A completes normally.
- MSX_CART_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16: read with bus_ready never asserted -> twait falls after 16 cycles, td_out=8'hFF, td_oe=1 until n_rd releases; a late bus_rdata_en has no effect.
- ADDR_W=14, SYNC_STAGES=3: write at ta=14'h3FFF -> bus_address=14'h3FFF; bus_valid rises 4 cycles after the n_wr falling edge.

Source files
------------

// File: rtl/msx_cart_bus_if_if.sv
// Internal request bus between the MSX slot front end and its target.
// master: the slot front end (issues requests); slave: the target that serves them.
interface msx_cart_bus_if_if #(
  parameter int ADDR_W = 2
);
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_write;
  logic [ADDR_W-1:0] bus_address;
  logic [7:0]        bus_wdata;
  logic [7:0]        bus_rdata;
  logic              bus_rdata_en;

  modport master (
    output bus_valid,
    output bus_write,
    output bus_address,
    output bus_wdata,
    input  bus_ready,
    input  bus_rdata,
    input  bus_rdata_en
  );

  modport slave (
    input  bus_valid,
    input  bus_write,
    input  bus_address,
    input  bus_wdata,
    output bus_ready,
    output bus_rdata,
    output bus_rdata_en
  );
endinterface

// File: rtl/msx_cart_bus_if.sv
// MSX cartridge slot bus front end.
// Synchronises the slot strobes, turns each slot access into exactly one
// valid/ready request on the internal bus, returns read data onto the slot
// and holds the slot in wait (twait) until the target has answered.
// Optional feature macro: MSX_CART_BUS_TIMEOUT_EN -- abandons a stalled
// request after TIMEOUT_CYCLES clocks (reads then return 8'hFF).
// SYNC_STAGES must lie in 2..4.
module msx_cart_bus_if #(
  parameter int ADDR_W         = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              n_ce,
  input  logic              n_wr,
  input  logic              n_rd,
  input  logic [ADDR_W-1:0] ta,
  input  logic [7:0]        td_in,
  output logic [7:0]        td_out,
  output logic              td_oe,
  output logic              twait,
  msx_cart_bus_if_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD_WAIT,
    ST_DRIVE,
    ST_RELEASE
  } state_t;

  // Strobes packed as {ce, wr, rd}; index 2 = ce, 1 = wr, 0 = rd.
  logic [2:0] w_strobe_n;
  logic [2:0] w_strobe;
  logic       w_s_ce;
  logic       w_s_wr;
  logic       w_s_rd;

  assign w_strobe_n = {n_ce, n_wr, n_rd};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      // Shift the raw active-low strobe through the synchroniser chain; idle (1) after reset.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_sync <= '1;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_strobe_n[gi]};
        end
      end

      assign w_strobe[gi] = ~r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_s_ce = w_strobe[2];
  assign w_s_wr = w_strobe[1];
  assign w_s_rd = w_strobe[0];

  state_t            r_state;
  state_t            w_state_next;
  logic              r_bus_valid;
  logic              w_bus_valid_next;
  logic              r_bus_write;
  logic              w_bus_write_next;
  logic [ADDR_W-1:0] r_bus_address;
  logic [ADDR_W-1:0] w_bus_address_next;
  logic [7:0]        r_bus_wdata;
  logic [7:0]        w_bus_wdata_next;
  logic [7:0]        r_td_out;
  logic [7:0]        w_td_out_next;
  logic              r_td_oe;
  logic              w_td_oe_next;
  logic              r_twait;
  logic              w_twait_next;
  logic              w_start;

  // A request starts only for a single, unambiguous strobe under chip enable.
  assign w_start = w_s_ce && (w_s_wr ^ w_s_rd);

`ifdef MSX_CART_BUS_TIMEOUT_EN
  function automatic int tmo_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

  localparam int TMO_W = tmo_width(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_waiting;

  assign w_waiting = (r_state == ST_REQ) || (r_state == ST_RD_WAIT);

  // Count cycles spent waiting on the target; restart on any state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
    end else if (!w_waiting || (w_state_next != r_state)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and registered-output logic of the slot access sequencer.
  always_comb begin
    w_state_next       = r_state;
    w_bus_valid_next   = r_bus_valid;
    w_bus_write_next   = r_bus_write;
    w_bus_address_next = r_bus_address;
    w_bus_wdata_next   = r_bus_wdata;
    w_td_out_next      = r_td_out;
    w_td_oe_next       = r_td_oe;
    w_twait_next       = r_twait;

    case (r_state)
      ST_IDLE: begin
        w_twait_next = 1'b0;
        if (w_start) begin
          w_bus_address_next = ta;
          w_bus_write_next   = w_s_wr;
          if (w_s_wr) begin
            w_bus_wdata_next = td_in;
          end
          w_bus_valid_next = 1'b1;
          w_twait_next     = 1'b1;
          w_state_next     = ST_REQ;
        end
      end

      ST_REQ: begin
        if (bus.bus_ready) begin
          w_bus_valid_next = 1'b0;
          if (r_bus_write) begin
            w_twait_next = 1'b0;
            w_state_next = ST_RELEASE;
          end else if (bus.bus_rdata_en) begin
            // Data came with the handshake: skip RD_WAIT.
            w_twait_next = 1'b0;
            if (w_s_rd && w_s_ce) begin
              w_td_out_next = bus.bus_rdata;
              w_td_oe_next  = 1'b1;
              w_state_next  = ST_DRIVE;
            end else begin
              w_state_next = ST_RELEASE;
            end
          end else begin
            w_state_next = ST_RD_WAIT;
          end
        end
      end

      ST_RD_WAIT: begin
        if (bus.bus_rdata_en) begin
          w_twait_next = 1'b0;
          // Slot already gone: finish the request but never drive td.
          if (w_s_rd && w_s_ce) begin
            w_td_out_next = bus.bus_rdata;
            w_td_oe_next  = 1'b1;
            w_state_next  = ST_DRIVE;
          end else begin
            w_state_next = ST_RELEASE;
          end
        end
      end

      ST_DRIVE: begin
        w_twait_next = 1'b0;
        if (!w_s_rd || !w_s_ce) begin
          w_td_oe_next = 1'b0;
          w_state_next = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        w_twait_next = 1'b0;
        w_td_oe_next = 1'b0;
        if (!w_s_ce && !w_s_wr && !w_s_rd) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next     = ST_IDLE;
        w_bus_valid_next = 1'b0;
        w_twait_next     = 1'b0;
        w_td_oe_next     = 1'b0;
      end
    endcase

`ifdef MSX_CART_BUS_TIMEOUT_EN
    // Give up on a silent target; a real response in this cycle takes priority.
    if (w_waiting && (w_state_next == r_state) && (r_tmo_cnt == TMO_LAST)) begin
      w_bus_valid_next = 1'b0;
      w_twait_next     = 1'b0;
      if (r_bus_write) begin
        w_state_next = ST_RELEASE;
      end else begin
        w_td_out_next = 8'hFF;
        w_td_oe_next  = 1'b1;
        w_state_next  = ST_DRIVE;
      end
    end
`endif
  end

  // State and output registers; reset drops any pending request silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_bus_valid   <= 1'b0;
      r_bus_write   <= 1'b0;
      r_bus_address <= '0;
      r_bus_wdata   <= 8'h00;
      r_td_out      <= 8'h00;
      r_td_oe       <= 1'b0;
      r_twait       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_bus_valid   <= w_bus_valid_next;
      r_bus_write   <= w_bus_write_next;
      r_bus_address <= w_bus_address_next;
      r_bus_wdata   <= w_bus_wdata_next;
      r_td_out      <= w_td_out_next;
      r_td_oe       <= w_td_oe_next;
      r_twait       <= w_twait_next;
    end
  end

  assign bus.bus_valid   = r_bus_valid;
  assign bus.bus_write   = r_bus_write;
  assign bus.bus_address = r_bus_address;
  assign bus.bus_wdata   = r_bus_wdata;
  assign td_out          = r_td_out;
  assign td_oe           = r_td_oe;
  assign twait           = r_twait;

endmodule

// File: tb/tb_msx_cart_bus_if.sv
// Self-checking bench for msx_cart_bus_if: a per-cycle vector table for the
// basic write/read/illegal-strobe flow, plus hand-written multi-cycle sequences.
// Build with MSX_CART_BUS_TIMEOUT_EN defined to also exercise the timeout path.
module tb_msx_cart_bus_if;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: ADDR_W=2, SYNC_STAGES=2
  logic       n_ce = 1'b1, n_wr = 1'b1, n_rd = 1'b1;
  logic [1:0] ta = '0;
  logic [7:0] td_in = '0;
  logic [7:0] td_out;
  logic       td_oe, twait;
  logic       rdy = 1'b0, rd_en = 1'b0;
  logic [7:0] rdata = '0;

  msx_cart_bus_if_if #(.ADDR_W(2)) u_bus ();
  assign u_bus.bus_ready    = rdy;
  assign u_bus.bus_rdata    = rdata;
  assign u_bus.bus_rdata_en = rd_en;

  msx_cart_bus_if #(.ADDR_W(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .n_ce(n_ce), .n_wr(n_wr), .n_rd(n_rd),
    .ta(ta), .td_in(td_in), .td_out(td_out), .td_oe(td_oe), .twait(twait),
    .bus(u_bus)
  );

  // Second DUT: ADDR_W=14, SYNC_STAGES=3
  logic        n_ce2 = 1'b1, n_wr2 = 1'b1, n_rd2 = 1'b1;
  logic [13:0] ta2 = '0;
  logic [7:0]  td_in2 = '0;
  logic [7:0]  td_out2;
  logic        td_oe2, twait2;

  msx_cart_bus_if_if #(.ADDR_W(14)) u_bus2 ();
  assign u_bus2.bus_ready    = 1'b1;
  assign u_bus2.bus_rdata    = 8'h00;
  assign u_bus2.bus_rdata_en = 1'b0;

  msx_cart_bus_if #(.ADDR_W(14), .SYNC_STAGES(3)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .n_ce(n_ce2), .n_wr(n_wr2), .n_rd(n_rd2),
    .ta(ta2), .td_in(td_in2), .td_out(td_out2), .td_oe(td_oe2), .twait(twait2),
    .bus(u_bus2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic ce, input logic wr, input logic rd,
                      input logic [1:0] a, input logic [7:0] d);
    n_ce = ce; n_wr = wr; n_rd = rd; ta = a; td_in = d;
  endtask

  typedef struct {
    logic       ce, wr, rd;
    logic [1:0] a;
    logic [7:0] d;
    logic       rdy;
    logic [7:0] rdata;
    logic       en;
    logic       e_valid, e_write;
    logic [1:0] e_addr;
    logic [7:0] e_wdata;
    logic       e_twait, e_oe;
    logic [7:0] e_out;
    int         reps;
  } vec_t;

  function automatic vec_t mk(
      input logic ce, input logic wr, input logic rd, input logic [1:0] a,
      input logic [7:0] d, input logic r, input logic [7:0] rdt, input logic en,
      input logic ev, input logic ew, input logic [1:0] ea, input logic [7:0] ed,
      input logic etw, input logic eoe, input logic [7:0] eo, input int reps);
    vec_t v;
    v.ce = ce; v.wr = wr; v.rd = rd; v.a = a; v.d = d;
    v.rdy = r; v.rdata = rdt; v.en = en;
    v.e_valid = ev; v.e_write = ew; v.e_addr = ea; v.e_wdata = ed;
    v.e_twait = etw; v.e_oe = eoe; v.e_out = eo; v.reps = reps;
    return v;
  endfunction

  localparam int NV = 16;
  vec_t vecs[NV];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int first;
    int n;

    // Write (ready tied 1), read with delayed ready/data, then illegal and idle strobes.
    vecs[0]  = mk(0,0,1,2,8'hA5,1,8'h00,0, 0,0,0,8'h00,0,0,8'h00,2);
    vecs[1]  = mk(0,0,1,2,8'hA5,1,8'h00,0, 1,1,2,8'hA5,1,0,8'h00,1);
    vecs[2]  = mk(0,0,1,2,8'hA5,1,8'h00,0, 0,1,2,8'hA5,0,0,8'h00,2);
    vecs[3]  = mk(1,1,1,2,8'hA5,1,8'h00,0, 0,1,2,8'hA5,0,0,8'h00,3);
    vecs[4]  = mk(0,1,0,1,8'h00,0,8'h00,0, 0,1,2,8'hA5,0,0,8'h00,2);
    vecs[5]  = mk(0,1,0,1,8'h00,0,8'h00,0, 1,0,1,8'hA5,1,0,8'h00,3);
    vecs[6]  = mk(0,1,0,1,8'h00,1,8'h00,0, 0,0,1,8'hA5,1,0,8'h00,1);
    vecs[7]  = mk(0,1,0,1,8'h00,0,8'h00,0, 0,0,1,8'hA5,1,0,8'h00,4);
    vecs[8]  = mk(0,1,0,1,8'h00,0,8'h3C,1, 0,0,1,8'hA5,0,1,8'h3C,1);
    vecs[9]  = mk(0,1,0,1,8'h00,0,8'h00,0, 0,0,1,8'hA5,0,1,8'h3C,2);
    vecs[10] = mk(0,1,1,1,8'h00,0,8'h00,0, 0,0,1,8'hA5,0,1,8'h3C,2);
    vecs[11] = mk(0,1,1,1,8'h00,0,8'h00,0, 0,0,1,8'hA5,0,0,8'h3C,1);
    vecs[12] = mk(1,1,1,1,8'h00,0,8'h00,0, 0,0,1,8'hA5,0,0,8'h3C,3);
    vecs[13] = mk(0,0,0,1,8'h00,0,8'h00,0, 0,0,1,8'hA5,0,0,8'h3C,4);
    vecs[14] = mk(0,1,1,1,8'h00,0,8'h00,0, 0,0,1,8'hA5,0,0,8'h3C,4);
    vecs[15] = mk(1,1,1,1,8'h00,0,8'h00,0, 0,0,1,8'hA5,0,0,8'h3C,3);

    // Reset state
    step(); step();
    chk("reset td_out", 32'(td_out), 32'h00);
    chk("reset td_oe", 32'(td_oe), 32'h0);
    chk("reset twait", 32'(twait), 32'h0);
    chk("reset valid", 32'(u_bus.bus_valid), 32'h0);
    chk("reset write", 32'(u_bus.bus_write), 32'h0);
    chk("reset addr", 32'(u_bus.bus_address), 32'h0);
    chk("reset wdata", 32'(u_bus.bus_wdata), 32'h00);
    @(negedge clk);
    reset_n = 1'b1;
    step(); step();

    // Table-driven per-cycle vectors
    for (int i = 0; i < NV; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        @(negedge clk);
        slot(vecs[i].ce, vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d);
        rdy = vecs[i].rdy; rdata = vecs[i].rdata; rd_en = vecs[i].en;
        step();
        $display("vec %0d.%0d: valid=%0b write=%0b addr=%0h wdata=%0h twait=%0b oe=%0b td_out=%0h",
                 i, r, u_bus.bus_valid, u_bus.bus_write, u_bus.bus_address,
                 u_bus.bus_wdata, twait, td_oe, td_out);
        chk($sformatf("v%0d.%0d valid", i, r), 32'(u_bus.bus_valid), 32'(vecs[i].e_valid));
        chk($sformatf("v%0d.%0d write", i, r), 32'(u_bus.bus_write), 32'(vecs[i].e_write));
        chk($sformatf("v%0d.%0d addr", i, r), 32'(u_bus.bus_address), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d.%0d wdata", i, r), 32'(u_bus.bus_wdata), 32'(vecs[i].e_wdata));
        chk($sformatf("v%0d.%0d twait", i, r), 32'(twait), 32'(vecs[i].e_twait));
        chk($sformatf("v%0d.%0d td_oe", i, r), 32'(td_oe), 32'(vecs[i].e_oe));
        chk($sformatf("v%0d.%0d td_out", i, r), 32'(td_out), 32'(vecs[i].e_out));
      end
    end

    // Read where ready and rdata_en coincide: straight to DRIVE
    @(negedge clk); slot(0,1,0,3,8'h00); rdy = 0; rd_en = 0;
    step(); step(); step();
    chk("same-cycle valid", 32'(u_bus.bus_valid), 32'h1);
    @(negedge clk); rdy = 1; rd_en = 1; rdata = 8'hC3;
    step();
    $display("same-cycle read: oe=%0b td_out=%0h twait=%0b", td_oe, td_out, twait);
    chk("same-cycle td_oe", 32'(td_oe), 32'h1);
    chk("same-cycle td_out", 32'(td_out), 32'hC3);
    chk("same-cycle twait", 32'(twait), 32'h0);
    chk("same-cycle valid drop", 32'(u_bus.bus_valid), 32'h0);
    @(negedge clk); rdy = 0; rd_en = 0; rdata = 8'h00; slot(1,1,1,3,8'h00);
    step(); step(); step();
    chk("same-cycle oe release", 32'(td_oe), 32'h0);
    step(); step(); step();

    // Early strobe release while waiting for read data
    @(negedge clk); slot(0,1,0,2,8'h00);
    step(); step(); step();
    chk("early valid", 32'(u_bus.bus_valid), 32'h1);
    @(negedge clk); rdy = 1;
    step();
    @(negedge clk); rdy = 0; slot(1,1,1,2,8'h00);
    step(); step(); step(); step();
    chk("early twait held", 32'(twait), 32'h1);
    chk("early oe low", 32'(td_oe), 32'h0);
    @(negedge clk); rd_en = 1; rdata = 8'h77;
    step();
    $display("early-release read: twait=%0b oe=%0b td_out=%0h", twait, td_oe, td_out);
    chk("early twait fall", 32'(twait), 32'h0);
    chk("early oe never", 32'(td_oe), 32'h0);
    chk("early td_out kept", 32'(td_out), 32'hC3);
    @(negedge clk); rd_en = 0; rdata = 8'h00;
    step(); step(); step();
    chk("early oe after", 32'(td_oe), 32'h0);

    // Asynchronous reset while in RD_WAIT, then a fresh write
    @(negedge clk); slot(0,1,0,1,8'h00);
    step(); step(); step();
    @(negedge clk); rdy = 1;
    step();
    @(negedge clk); rdy = 0;
    step();
    chk("rst pre twait", 32'(twait), 32'h1);
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    $display("async reset: twait=%0b valid=%0b oe=%0b", twait, u_bus.bus_valid, td_oe);
    chk("rst twait", 32'(twait), 32'h0);
    chk("rst valid", 32'(u_bus.bus_valid), 32'h0);
    chk("rst td_oe", 32'(td_oe), 32'h0);
    chk("rst addr", 32'(u_bus.bus_address), 32'h0);
    slot(1,1,1,0,8'h00);
    step(); step();
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); slot(0,0,1,0,8'h5A); rdy = 1;
    step(); step(); step();
    $display("post-reset write: valid=%0b addr=%0h wdata=%0h", u_bus.bus_valid, u_bus.bus_address, u_bus.bus_wdata);
    chk("post-rst valid", 32'(u_bus.bus_valid), 32'h1);
    chk("post-rst write", 32'(u_bus.bus_write), 32'h1);
    chk("post-rst addr", 32'(u_bus.bus_address), 32'h0);
    chk("post-rst wdata", 32'(u_bus.bus_wdata), 32'h5A);
    chk("post-rst twait", 32'(twait), 32'h1);
    step();
    chk("post-rst valid drop", 32'(u_bus.bus_valid), 32'h0);
    chk("post-rst twait drop", 32'(twait), 32'h0);
    @(negedge clk); slot(1,1,1,0,8'h00); rdy = 0;
    step(); step(); step();

    // Wide address, three-stage synchroniser: bus_valid on the 4th edge
    @(negedge clk); n_ce2 = 0; n_wr2 = 0; ta2 = 14'h3FFF; td_in2 = 8'h99;
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (first == 0 && u_bus2.bus_valid) begin
        first = k;
        chk("wide addr", 32'(u_bus2.bus_address), 32'h3FFF);
        chk("wide wdata", 32'(u_bus2.bus_wdata), 32'h99);
      end
    end
    $display("wide write: valid after %0d edges", first);
    chk("wide latency", 32'(first), 32'd4);
    @(negedge clk); n_ce2 = 1; n_wr2 = 1;
    step(); step(); step(); step();

`ifdef MSX_CART_BUS_TIMEOUT_EN
    // Read against a target that never answers
    @(negedge clk); slot(0,1,0,1,8'h00); rdy = 0; rd_en = 0;
    step(); step(); step();
    chk("tmo twait start", 32'(twait), 32'h1);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (!twait) begin
        n = k;
        break;
      end
    end
    $display("timeout read: twait fell after %0d cycles, td_out=%0h oe=%0b", n, td_out, td_oe);
    chk("tmo cycles", 32'(n), 32'd16);
    chk("tmo td_out", 32'(td_out), 32'hFF);
    chk("tmo td_oe", 32'(td_oe), 32'h1);
    chk("tmo valid", 32'(u_bus.bus_valid), 32'h0);
    @(negedge clk); rdy = 1; rd_en = 1; rdata = 8'h12;
    step();
    chk("tmo late data", 32'(td_out), 32'hFF);
    chk("tmo late twait", 32'(twait), 32'h0);
    @(negedge clk); rdy = 0; rd_en = 0; slot(1,1,1,1,8'h00);
    step(); step(); step();
    chk("tmo oe release", 32'(td_oe), 32'h0);
    step(); step(); step();
`else
    n = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
